// File: rtl/ram_initiator_pkg.sv
// ram_initiator_pkg: definitions shared by the RAM request master and its helpers.
//   state_e          - 3-bit controller state encoding
//   RAM_READ_LATENCY - registered read latency of the attached ram (cycles)
//   state_is_busy()  - decode of the busy status from a state
package ram_initiator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WRITE      = 3'd1,
    ST_READ_ISSUE = 3'd2,
    ST_READ_WAIT  = 3'd3,
    ST_RESP       = 3'd4,
    ST_CLEAR      = 3'd5
  } state_e;

  localparam int unsigned RAM_READ_LATENCY = 32'd1;

  function automatic logic state_is_busy(input state_e state);
    return (state != ST_IDLE);
  endfunction

endpackage

// File: rtl/ram_clear_sequencer.sv
// ram_clear_sequencer: address counter for the power-up clear sweep.
//   clock     - rising-edge clock
//   start_i   - synchronous restart, forces the count to 0
//   advance_i - step the count by one (wraps from all-ones to 0)
//   count_o   - current sweep address
//   last_o    - count_o is the final address of the sweep
// Only instantiated when RAM_INITIATOR_CLEAR_EN is defined.
module ram_clear_sequencer #(
  parameter int unsigned ADDR_BITS = 16
) (
  input  logic                 clock,
  input  logic                 start_i,
  input  logic                 advance_i,
  output logic [ADDR_BITS-1:0] count_o,
  output logic                 last_o
);

  logic [ADDR_BITS-1:0] count_q;

  // Sweep counter: restart on start, otherwise step when told to.
  always_ff @(posedge clock) begin
    if (start_i) begin
      count_q <= {ADDR_BITS{1'b0}};
    end else if (advance_i) begin
      count_q <= count_q + ADDR_BITS'(1'b1);
    end else begin
      count_q <= count_q;
    end
  end

  assign count_o = count_q;
  assign last_o  = &count_q;

endmodule

// File: rtl/ram_initiator.sv
// ram_initiator: request-side master for the single-port synchronous ram.
//   clock, reset       - single rising-edge clock, synchronous active-high reset
//   req_*              - valid/ready request channel from the core (write or read)
//   rsp_*              - held valid/ready read-response channel
//   busy               - controller not idle (also high while reset is asserted)
//   ram_write_enable, ram_address, ram_data_out - registered pins to the ram
//   ram_data_in        - ram read data, valid one cycle after the address
// Build option RAM_INITIATOR_CLEAR_EN: after reset, sweep every address writing
// CLEAR_VALUE before accepting requests.
module ram_initiator
  import ram_initiator_pkg::*;
#(
  parameter int unsigned          ADDR_BITS   = 16,
  parameter int unsigned          DATA_BITS   = 8,
  parameter logic [DATA_BITS-1:0] CLEAR_VALUE = {DATA_BITS{1'b0}}
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDR_BITS-1:0] req_address,
  input  logic [DATA_BITS-1:0] req_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_BITS-1:0] rsp_data,
  output logic                 busy,
  output logic                 ram_write_enable,
  output logic [ADDR_BITS-1:0] ram_address,
  output logic [DATA_BITS-1:0] ram_data_out,
  input  logic [DATA_BITS-1:0] ram_data_in
);

`ifdef RAM_INITIATOR_CLEAR_EN
  // Reset lands directly on the first sweep write (address 0).
  localparam state_e               RESET_STATE = ST_CLEAR;
  localparam logic                 RESET_WE    = 1'b1;
  localparam logic [DATA_BITS-1:0] RESET_WDATA = CLEAR_VALUE;
`else
  localparam state_e               RESET_STATE = ST_IDLE;
  localparam logic                 RESET_WE    = 1'b0;
  localparam logic [DATA_BITS-1:0] RESET_WDATA = {DATA_BITS{1'b0}};
`endif

  state_e               state_q,    state_d;
  logic                 ram_we_q,   ram_we_d;
  logic [ADDR_BITS-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_BITS-1:0] ram_wdat_q, ram_wdat_d;
  logic [DATA_BITS-1:0] rsp_data_q, rsp_data_d;

`ifdef RAM_INITIATOR_CLEAR_EN
  logic                 clr_advance_s;
  logic [ADDR_BITS-1:0] clr_count_s;
  logic                 clr_last_s;

  ram_clear_sequencer #(
    .ADDR_BITS (ADDR_BITS)
  ) u_clear_seq (
    .clock     (clock),
    .start_i   (reset),
    .advance_i (clr_advance_s),
    .count_o   (clr_count_s),
    .last_o    (clr_last_s)
  );
`else
  logic unused_clear_value_s;
  assign unused_clear_value_s = ^CLEAR_VALUE;
`endif

  // Next-state and next ram-pin values; ram_write_enable defaults low.
  always_comb begin
    state_d    = state_q;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_wdat_d = ram_wdat_q;
    rsp_data_d = rsp_data_q;
`ifdef RAM_INITIATOR_CLEAR_EN
    clr_advance_s = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          ram_addr_d = req_address;
          if (req_write) begin
            state_d    = ST_WRITE;
            ram_we_d   = 1'b1;
            ram_wdat_d = req_data;
          end else begin
            state_d = ST_READ_ISSUE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE:      state_d = ST_IDLE;
      ST_READ_ISSUE: state_d = ST_READ_WAIT;
      ST_READ_WAIT: begin
        // ram output register now holds the addressed word.
        rsp_data_d = ram_data_in;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
`ifdef RAM_INITIATOR_CLEAR_EN
      ST_CLEAR: begin
        // ram pins already present the current count; queue the next address.
        clr_advance_s = 1'b1;
        if (clr_last_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d    = ST_CLEAR;
          ram_we_d   = 1'b1;
          ram_addr_d = clr_count_s + ADDR_BITS'(1'b1);
          ram_wdat_d = CLEAR_VALUE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered ram/response pins.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= RESET_STATE;
      ram_we_q   <= RESET_WE;
      ram_addr_q <= {ADDR_BITS{1'b0}};
      ram_wdat_q <= RESET_WDATA;
      rsp_data_q <= {DATA_BITS{1'b0}};
    end else begin
      state_q    <= state_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_wdat_q <= ram_wdat_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  // Reset masks handshakes and the write strobe in the same cycle, so a write
  // whose WRITE cycle meets reset never reaches the ram.
  assign req_ready        = (state_q == ST_IDLE) && !reset;
  assign rsp_valid        = (state_q == ST_RESP) && !reset;
  assign busy             = state_is_busy(state_q) || reset;
  assign ram_write_enable = ram_we_q && !reset;
  assign ram_address      = ram_addr_q;
  assign ram_data_out     = ram_wdat_q;
  assign rsp_data         = rsp_data_q;

endmodule
